// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - shared constants, IV and state encoding for the SHA-256 chaining-state bank
package sha256_pkg;
   localparam int SHA_WIDTH = 32;
   localparam int SHA_WORDS = 8;
   localparam int SHA_CNT_W = 8;

   // word 0 (H0) occupies the least significant 32 bits
   localparam logic [SHA_WORDS*SHA_WIDTH-1:0] SHA_IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PASS1 = 2'd1,
      ST_PASS2 = 2'd2,
      ST_DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/hstate_adder.sv
// rtl/hstate_adder.sv - combinational WORDS-lane modular adder (carry discarded per lane)
module hstate_adder #(
   parameter int WIDTH = 32,
   parameter int WORDS = 8
) (
   input  logic [WORDS*WIDTH-1:0] i_a,
   input  logic [WORDS*WIDTH-1:0] i_b,
   output logic [WORDS*WIDTH-1:0] o_sum
);
   for (genvar g = 0; g < WORDS; g++) begin : g_lane
      assign o_sum[g*WIDTH +: WIDTH] = i_a[g*WIDTH +: WIDTH] + i_b[g*WIDTH +: WIDTH];
   end
endmodule

// File: rtl/sha256_hstate_bank.sv
// rtl/sha256_hstate_bank.sv - SHA-256 chaining-state bank sequencing single/double passes
// Optional midstate capture/resume enabled by defining SHA_MIDSTATE_EN.
module sha256_hstate_bank
   import sha256_pkg::*;
#(
   parameter int WIDTH = SHA_WIDTH,
   parameter int WORDS = SHA_WORDS,
   parameter int CNT_W = SHA_CNT_W,
   parameter logic [WORDS*WIDTH-1:0] IV = SHA_IV
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   double_en,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_last,
   input  logic [WORDS*WIDTH-1:0] in_words,
   output logic [WORDS*WIDTH-1:0] h_state,
   output logic [CNT_W-1:0]       blk_cnt,
   output logic [WORDS*WIDTH-1:0] p1_digest,
   output logic [WORDS*WIDTH-1:0] digest,
   output logic                   digest_valid,
   input  logic                   digest_ready,
`ifdef SHA_MIDSTATE_EN
   input  logic                   start_mid,
   output logic                   mid_valid,
`endif
   output logic                   busy
);
   state_t                 r_state;
   logic                   r_double;
   logic                   r_dv;
   logic [WORDS*WIDTH-1:0] r_h, r_p1, r_dig;
   logic [CNT_W-1:0]       r_cnt;
   logic [WORDS*WIDTH-1:0] w_sum, w_load_h;
   logic [CNT_W-1:0]       w_cnt_inc, w_load_cnt;
   logic                   w_accept, w_can_start, w_go, w_go_mid;

   hstate_adder #(.WIDTH(WIDTH), .WORDS(WORDS)) u_adder (
      .i_a  (r_h),
      .i_b  (in_words),
      .o_sum(w_sum)
   );

   assign in_ready     = (r_state == ST_PASS1) || (r_state == ST_PASS2);
   assign busy         = (r_state != ST_IDLE);
   assign h_state      = r_h;
   assign blk_cnt      = r_cnt;
   assign p1_digest    = r_p1;
   assign digest       = r_dig;
   assign digest_valid = r_dv;

   assign w_accept    = in_valid && in_ready;
   assign w_can_start = (r_state == ST_IDLE) || ((r_state == ST_DONE) && digest_ready);
   assign w_go        = w_can_start && start;
   assign w_cnt_inc   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);

`ifdef SHA_MIDSTATE_EN
   logic [WORDS*WIDTH-1:0] r_mid;
   logic                   r_mid_valid;
   assign mid_valid  = r_mid_valid;
   assign w_go_mid   = w_can_start && !start && start_mid && r_mid_valid;
   assign w_load_h   = w_go ? IV : r_mid;
   assign w_load_cnt = w_go ? '0 : CNT_W'(1);

   // midstate is the chaining value after the first non-final block of PASS1
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mid       <= '0;
         r_mid_valid <= 1'b0;
      end else if (w_go) begin
         r_mid_valid <= 1'b0;
      end else if (w_accept && (r_state == ST_PASS1) && (r_cnt == '0) && !in_last) begin
         r_mid       <= w_sum;
         r_mid_valid <= 1'b1;
      end
   end
`else
   assign w_go_mid   = 1'b0;
   assign w_load_h   = IV;
   assign w_load_cnt = '0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_double <= 1'b0;
         r_dv     <= 1'b0;
         r_h      <= IV;
         r_p1     <= '0;
         r_dig    <= '0;
         r_cnt    <= '0;
      end else if (w_go || w_go_mid) begin
         r_state  <= ST_PASS1;
         r_double <= double_en;
         r_dv     <= 1'b0;
         r_h      <= w_load_h;
         r_cnt    <= w_load_cnt;
      end else begin
         case (r_state)
            ST_DONE: begin
               if (digest_ready) begin
                  r_dv    <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            ST_PASS1, ST_PASS2: begin
               if (w_accept) begin
                  r_cnt <= w_cnt_inc;
                  if (!in_last) begin
                     r_h <= w_sum;
                  end else if ((r_state == ST_PASS1) && r_double) begin
                     // second pass hashes the first digest from a fresh IV
                     r_p1    <= w_sum;
                     r_h     <= IV;
                     r_cnt   <= '0;
                     r_state <= ST_PASS2;
                  end else begin
                     r_dig   <= w_sum;
                     r_dv    <= 1'b1;
                     r_h     <= w_sum;
                     r_state <= ST_DONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_sha256_hstate_bank.sv
// tb/tb_sha256_hstate_bank.sv - randomized self-checking bench for sha256_hstate_bank
module tb_sha256_hstate_bank;
   localparam logic [255:0] TB_IV = {
      32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
      32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0, double_en = 1'b0, in_valid = 1'b0, in_last = 1'b0;
   logic         digest_ready = 1'b0, start_mid = 1'b0;
   logic [255:0] in_words = '0;
   logic         in_ready, digest_valid, busy;
   logic [255:0] h_state, p1_digest, digest;
   logic [7:0]   blk_cnt;
`ifdef SHA_MIDSTATE_EN
   logic         mid_valid;
`endif

   int vec = 0;
   int errs = 0;

   sha256_hstate_bank dut (
      .clk(clk), .rst(rst), .start(start), .double_en(double_en),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .in_words(in_words),
      .h_state(h_state), .blk_cnt(blk_cnt), .p1_digest(p1_digest), .digest(digest),
      .digest_valid(digest_valid), .digest_ready(digest_ready),
`ifdef SHA_MIDSTATE_EN
      .start_mid(start_mid), .mid_valid(mid_valid),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] fill(input logic [31:0] v);
      return {8{v}};
   endfunction

   // reference: eight independent 32-bit sums, carry out of each word dropped
   function automatic logic [255:0] add8(input logic [255:0] a, input logic [255:0] b);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = 32'(a[i*32 +: 32] + b[i*32 +: 32]);
      return r;
   endfunction

   task automatic beat(input logic [255:0] w, input logic last);
      in_valid = 1'b1; in_words = w; in_last = last;
      cyc();
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic begin_msg(input logic dbl);
      start = 1'b1; double_en = dbl;
      cyc();
      start = 1'b0;
   endtask

   task automatic release_digest();
      digest_ready = 1'b1;
      cyc();
      digest_ready = 1'b0;
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL release_idle: busy=%b expected 0", busy); end
   endtask

   task automatic test_reset();
      rst = 1'b1; cyc(); cyc();
      vec++; if (h_state !== TB_IV) begin errs++; $display("FAIL reset_h: got %h expected %h", h_state, TB_IV); end
      vec++; if (digest !== '0 || p1_digest !== '0) begin errs++; $display("FAIL reset_digests: got %h / %h expected 0", digest, p1_digest); end
      vec++; if ({digest_valid, in_ready, busy} !== 3'b000) begin errs++; $display("FAIL reset_flags: got %b expected 000", {digest_valid, in_ready, busy}); end
      vec++; if (blk_cnt !== 8'd0) begin errs++; $display("FAIL reset_cnt: got %0d expected 0", blk_cnt); end
      rst = 1'b0; cyc();
   endtask

   task automatic test_single();
      in_valid = 1'b1; in_words = fill(32'h1); cyc(); in_valid = 1'b0;
      vec++; if (h_state !== TB_IV || busy !== 1'b0) begin errs++; $display("FAIL idle_ignore: h=%h busy=%b expected IV,0", h_state, busy); end
      begin_msg(1'b0);
      vec++; if (in_ready !== 1'b1 || h_state !== TB_IV) begin errs++; $display("FAIL single_start: ready=%b h=%h expected 1,IV", in_ready, h_state); end
      beat(fill(32'h1), 1'b1);
      vec++; if (digest[31:0] !== 32'h6a09e668 || digest[63:32] !== 32'hbb67ae86) begin errs++; $display("FAIL single_digest: got %h expected 6a09e668/bb67ae86", digest[63:0]); end
      vec++; if ({digest_valid, in_ready, busy} !== 3'b101) begin errs++; $display("FAIL single_flags: got %b expected 101", {digest_valid, in_ready, busy}); end
      cyc(); cyc();
      vec++; if (busy !== 1'b1) begin errs++; $display("FAIL single_busy: got %b expected 1", busy); end
      release_digest();
   endtask

   task automatic test_double();
      logic [255:0] p1x;
      p1x = add8(TB_IV, fill(32'h1));
      begin_msg(1'b1);
      beat('0, 1'b0);
      beat(fill(32'h1), 1'b1);
      vec++; if (p1_digest !== p1x || p1_digest[63:32] !== 32'hbb67ae86) begin errs++; $display("FAIL double_p1: got %h expected %h", p1_digest, p1x); end
      vec++; if (h_state !== TB_IV || blk_cnt !== 8'd0 || digest_valid !== 1'b0) begin errs++; $display("FAIL double_pass2_entry: h=%h cnt=%0d dv=%b expected IV,0,0", h_state, blk_cnt, digest_valid); end
      beat('0, 1'b1);
      vec++; if (digest !== TB_IV || digest_valid !== 1'b1) begin errs++; $display("FAIL double_digest: got %h dv=%b expected IV,1", digest, digest_valid); end
      release_digest();
   endtask

   task automatic test_back_to_back();
      logic [255:0] acc;
      int n;
      acc = TB_IV; n = 0;
      begin_msg(1'b0);
      in_valid = 1'b1; in_words = fill(32'hffffffff); in_last = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc(); acc = add8(acc, fill(32'hffffffff)); n++;
         vec++; if (h_state !== acc || blk_cnt !== 8'(n)) begin errs++; $display("FAIL b2b_beat%0d: h=%h cnt=%0d expected %h,%0d", k, h_state, blk_cnt, acc, n); end
      end
      vec++; if (h_state[63:32] !== 32'hbb67ae82) begin errs++; $display("FAIL b2b_wrap: got %h expected bb67ae82", h_state[63:32]); end
      start = 1'b1; in_words = '0;
      for (int k = 0; k < 253; k++) cyc();
      start = 1'b0;
      vec++; if (blk_cnt !== 8'd255 || h_state !== acc) begin errs++; $display("FAIL b2b_sat: cnt=%0d h=%h expected 255,%h", blk_cnt, h_state, acc); end
      cyc();
      vec++; if (blk_cnt !== 8'd255) begin errs++; $display("FAIL b2b_sat_hold: got %0d expected 255", blk_cnt); end
      in_valid = 1'b0;
      beat('0, 1'b1);
      vec++; if (digest !== acc) begin errs++; $display("FAIL b2b_digest: got %h expected %h", digest, acc); end
      release_digest();
   endtask

   task automatic test_hold();
      logic [255:0] w, acc;
      w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      acc = add8(TB_IV, w);
      begin_msg(1'b0);
      beat(w, 1'b1);
      in_valid = 1'b1; in_words = fill(32'h5);
      for (int k = 0; k < 10; k++) begin
         cyc();
         vec++; if (digest_valid !== 1'b1 || digest !== acc || in_ready !== 1'b0) begin errs++; $display("FAIL hold_%0d: dv=%b dig=%h rdy=%b expected 1,%h,0", k, digest_valid, digest, in_ready, acc); end
      end
      in_valid = 1'b0;
      digest_ready = 1'b1; start = 1'b1; double_en = 1'b0;
      cyc();
      digest_ready = 1'b0; start = 1'b0;
      vec++; if (in_ready !== 1'b1 || h_state !== TB_IV || digest_valid !== 1'b0 || blk_cnt !== 8'd0) begin errs++; $display("FAIL hold_restart: rdy=%b h=%h dv=%b cnt=%0d expected 1,IV,0,0", in_ready, h_state, digest_valid, blk_cnt); end
      beat('0, 1'b1);
      release_digest();
   endtask

   task automatic test_random();
      logic [255:0] acc, w;
      logic dbl;
      int nb, cnt;
      for (int m = 0; m < 6; m++) begin
         dbl = 1'($urandom_range(0, 1));
         acc = TB_IV;
         begin_msg(dbl);
         for (int p = 1; p <= (dbl ? 2 : 1); p++) begin
            nb = $urandom_range(1, 4); cnt = 0;
            for (int b = 0; b < nb; b++) begin
               for (int g = $urandom_range(0, 2); g > 0; g--) cyc();
               w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
               beat(w, b == nb - 1);
               acc = add8(acc, w); cnt++;
               if (b != nb - 1) begin
                  vec++; if (h_state !== acc || blk_cnt !== 8'(cnt)) begin errs++; $display("FAIL rnd_m%0d_p%0d_b%0d: h=%h cnt=%0d expected %h,%0d", m, p, b, h_state, blk_cnt, acc, cnt); end
               end else if (p == 1 && dbl) begin
                  vec++; if (p1_digest !== acc || h_state !== TB_IV) begin errs++; $display("FAIL rnd_p1_m%0d: p1=%h h=%h expected %h,IV", m, p1_digest, h_state, acc); end
                  acc = TB_IV;
               end else begin
                  vec++; if (digest !== acc || digest_valid !== 1'b1) begin errs++; $display("FAIL rnd_dig_m%0d: got %h dv=%b expected %h,1", m, digest, digest_valid, acc); end
               end
            end
         end
         for (int g = $urandom_range(0, 3); g > 0; g--) cyc();
         release_digest();
      end
   endtask

   task automatic test_rst_mid();
      begin_msg(1'b1);
      beat(fill(32'h3), 1'b1);
      beat(fill(32'h7), 1'b0);
      rst = 1'b1; cyc(); rst = 1'b0;
      vec++; if (busy !== 1'b0 || h_state !== TB_IV || digest_valid !== 1'b0 || blk_cnt !== 8'd0 || p1_digest !== '0) begin errs++; $display("FAIL rst_mid: busy=%b h=%h dv=%b cnt=%0d p1=%h expected 0,IV,0,0,0", busy, h_state, digest_valid, blk_cnt, p1_digest); end
   endtask

`ifdef SHA_MIDSTATE_EN
   task automatic test_midstate();
      start_mid = 1'b1; cyc(); start_mid = 1'b0;
      vec++; if (busy !== 1'b0) begin errs++; $display("FAIL mid_ignored: busy=%b expected 0", busy); end
      begin_msg(1'b0);
      beat(fill(32'h1), 1'b0);
      vec++; if (mid_valid !== 1'b1) begin errs++; $display("FAIL mid_valid: got %b expected 1", mid_valid); end
      beat('0, 1'b1);
      release_digest();
      start_mid = 1'b1; cyc(); start_mid = 1'b0;
      vec++; if (h_state[31:0] !== 32'h6a09e668 || blk_cnt !== 8'd1 || in_ready !== 1'b1) begin errs++; $display("FAIL mid_resume: w0=%h cnt=%0d rdy=%b expected 6a09e668,1,1", h_state[31:0], blk_cnt, in_ready); end
      beat('0, 1'b1);
      release_digest();
   endtask
`endif

   initial begin
      test_reset();
`ifdef SHA_MIDSTATE_EN
      test_midstate();
`endif
      test_single();
      test_double();
      test_back_to_back();
      test_hold();
      test_random();
      test_rst_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule

// File: doc/sha256_hstate_bank.md
# sha256_hstate_bank

Parametrised chaining-state bank for the SHA-256 hashing core. It holds all WORDS hash words H0..H7 and feeds them to the compression round as the current chaining value. After each compressed block it adds the round's working variables (a..h) word-wise into the chaining value. It sequences single- and double-SHA passes and hands the final digest to the downstream compare/difficulty stage over a valid/ready handshake.

## Interface
- WIDTH, 32, bits per hash word.
- WORDS, 8, number of chaining words.
- CNT_W, 8, block-counter width.
- IV, {5be0cd19,1f83d9ab,9b05688c,510e527f,a54ff53a,3c6ef372,bb67ae85,6a09e667}, initial value as a WORDS*WIDTH vector; word i lives at [i*WIDTH +: WIDTH].

Ports (clock and reset first):
- clk  in  1  single clock, rising-edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  begin a new message; sampled only when accepted.
- double_en  in  1  latched with start: 1 = SHA256(SHA256(m)), 0 = SHA256(m).
- in_valid  in  1  compression result present.
- in_ready  out  1  bank accepts a compression result.
- in_last  in  1  qualifies in_valid: final block of the current pass.
- in_words  in  WORDS*WIDTH  compression working variables a..h.
- h_state  out  WORDS*WIDTH  current chaining value to the compressor.
- blk_cnt  out  CNT_W  blocks accepted in the current pass.
- p1_digest  out  WORDS*WIDTH  first-pass digest, used to build the second-pass message block.
- digest  out  WORDS*WIDTH  final digest.
- digest_valid  out  1  digest held for the consumer.
- digest_ready  in  1  consumer takes the digest.
- busy  out  1  state is not IDLE.

## Operation
- States:
  - IDLE: in_ready=0. start loads h_state<=IV, latches double_en, clears blk_cnt, and goes to PASS1.
  - PASS1 and PASS2: in_ready=1. On an accepted beat (in_valid&&in_ready), each word gets h_state[i] <= h_state[i] + in_words[i], mod 2^WIDTH with the carry discarded. blk_cnt increments and saturates at all-ones.
  - PASS1 with in_last and double=1:
    - p1_digest<=sum.
    - h_state<=IV.
    - blk_cnt<=0.
    - Go to PASS2.
  - PASS1 with in_last and double=0, or PASS2 with in_last:
    - digest<=sum.
    - digest_valid<=1.
    - h_state<=sum.
    - Go to DONE.
  - DONE: in_ready=0. digest_valid&&digest_ready clears digest_valid and goes to IDLE. If start is also high in that cycle, the bank goes straight to PASS1 with IV loaded.
- start in PASS1 or PASS2 is ignored. start in DONE without digest_ready is ignored.
- in_valid while in_ready=0 is ignored; no state changes.
- rst has priority over every event, in any state. Reset values:
  - State IDLE.
  - h_state=IV.
  - p1_digest=0.
  - digest=0.
  - digest_valid=0.
  - in_ready=0.
  - busy=0.
  - blk_cnt=0.
  - Midstate register and mid_valid cleared.

## Timing
- Accept-to-update latency is 1 cycle: h_state reflects the sum on the edge after the accepted beat.
- A back-to-back accept every cycle is legal in PASS1 and PASS2.
- digest_valid rises 1 cycle after the last-block accept. It stays stable, with digest held, until digest_ready.
- in_ready is registered-state decoded. It is low in the cycle digest_valid is high.

## Configuration
- SHA_MIDSTATE_EN defined:
  - Adds ports start_mid (in, 1) and mid_valid (out, 1).
  - On the first accepted PASS1 beat with in_last=0, the sum is captured into a midstate register and mid_valid<=1.
  - start_mid, accepted under the same rules as start, loads h_state<=midstate and blk_cnt<=1. It is legal only when mid_valid=1; otherwise it is ignored.
  - start has priority over start_mid in the same cycle. A plain start clears mid_valid.
- SHA_MIDSTATE_EN undefined: no midstate register and no extra ports. The bank behaves exactly as described above.

## Structure
- Package sha256_pkg holds:
  - The SHA-256 IV constant.
  - The state enum (IDLE, PASS1, PASS2, DONE).
  - Width constants.
- Sub-module hstate_adder: a combinational WORDS-lane modular adder, instantiated once, used for every sum.

## Test plan
- Reset, then single hash (double_en=0), one beat with in_words all 32'h00000001 and in_last=1 -> digest word0=6a09e668, word1=bb67ae86, digest_valid=1 one cycle later, busy=1 until digest_ready.
- Double hash with beats zeros/in_last=0, then all 32'h1/in_last=1 -> p1_digest word1=bb67ae86 and h_state=IV. A PASS2 beat of zeros/in_last=1 -> digest=IV.
- In PASS1, hold in_valid=1 for 3 cycles with all-ones words -> blk_cnt=3, word1 = bb67ae85 - 3 = bb67ae82 (wraps mod 2^32).
- digest_ready held low 10 cycles -> digest_valid and digest stable, in_ready=0. Then assert digest_ready and start together -> PASS1 with h_state=IV the next cycle.
- Assert rst mid-PASS2 -> next cycle IDLE, h_state=IV, digest_valid=0, blk_cnt=0.
- With SHA_MIDSTATE_EN: after the first beat of all 32'h1, mid_valid=1. A later start_mid loads h_state word0=6a09e668 and blk_cnt=1. start_mid with mid_valid=0 is ignored.
